// File: rtl/note_voice_if.sv
// Sequencer-facing bundle for one tone voice: note request in, tone and envelope out.
interface note_voice_if;
  logic [3:0] note_sustain;
  logic       sequencer_on;
  logic       square;
  logic [7:0] amp;
  logic [7:0] wave;
  logic       active;

  modport master (
    output note_sustain, sequencer_on,
    input  square, amp, wave, active
  );

  modport slave (
    input  note_sustain, sequencer_on,
    output square, amp, wave, active
  );
endinterface

// File: rtl/note_voice.sv
// Single square-wave voice with a linear attack/sustain/release envelope.
// Pitch changes are deferred to the next half-period boundary so the tone never emits a runt pulse.
module note_voice #(
  parameter int unsigned ATTACK_STEP  = 8,
  parameter int unsigned RELEASE_STEP = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  note_voice_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] counter_q, counter_d;
  logic [3:0] cur_note_q, cur_note_d;
  logic [3:0] pend_note_q, pend_note_d;
  logic       pend_valid_q, pend_valid_d;
  logic       square_q, square_d;
  logic [7:0] amp_q, amp_d;

  logic       note_valid;
  logic [3:0] next_note;
  logic [8:0] amp_up;
  logic [8:0] amp_down;

  // Half period in clocks for C4..B4 at a 10 kHz clock; codes outside 1..12 never reach the oscillator.
  function automatic logic [4:0] half_period(input logic [3:0] note);
    case (note)
      4'd1:    half_period = 5'd19;
      4'd2:    half_period = 5'd18;
      4'd3:    half_period = 5'd17;
      4'd4:    half_period = 5'd16;
      4'd5:    half_period = 5'd15;
      4'd6:    half_period = 5'd14;
      4'd7:    half_period = 5'd14;
      4'd8:    half_period = 5'd13;
      4'd9:    half_period = 5'd12;
      4'd10:   half_period = 5'd11;
      4'd11:   half_period = 5'd11;
      4'd12:   half_period = 5'd10;
      default: half_period = 5'd19;
    endcase
  endfunction

  assign note_valid = bus.sequencer_on && (bus.note_sustain != 4'd0) && (bus.note_sustain <= 4'd12);
  assign next_note  = pend_valid_q ? pend_note_q : cur_note_q;
  assign amp_up     = {1'b0, amp_q} + 9'(ATTACK_STEP);
  assign amp_down   = {1'b0, amp_q} - 9'(RELEASE_STEP);

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    cur_note_d   = cur_note_q;
    pend_note_d  = pend_note_q;
    pend_valid_d = pend_valid_q;
    square_d     = square_q;
    amp_d        = amp_q;

    if (state_q == IDLE) begin
      if (note_valid) begin
        state_d      = ATTACK;
        cur_note_d   = bus.note_sustain;
        square_d     = 1'b1;
        counter_d    = half_period(bus.note_sustain) - 5'd1;
        amp_d        = 8'd0;
        pend_valid_d = 1'b0;
      end
    end else begin
      if (counter_q == 5'd0) begin
        square_d     = ~square_q;
        cur_note_d   = next_note;
        counter_d    = half_period(next_note) - 5'd1;
        pend_valid_d = 1'b0;
      end else begin
        counter_d = counter_q - 5'd1;
      end

      // Compared against the note that will be sounding after this edge, so an applied pending is not re-latched.
      if (note_valid && (bus.note_sustain != cur_note_d)) begin
        pend_note_d  = bus.note_sustain;
        pend_valid_d = 1'b1;
      end

      case (state_q)
        ATTACK: begin
          if (!note_valid) begin
            state_d = RELEASE;
          end else begin
            amp_d = (amp_up > 9'd255) ? 8'hFF : amp_up[7:0];
            if (amp_d == 8'hFF) begin
              state_d = SUSTAIN;
            end
          end
        end
        SUSTAIN: begin
          if (!note_valid) begin
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (note_valid) begin
            state_d = ATTACK;
          end else begin
            amp_d = amp_down[8] ? 8'd0 : amp_down[7:0];
            if (amp_d == 8'd0) begin
              state_d      = IDLE;
              square_d     = 1'b0;
              pend_valid_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      counter_q    <= 5'd0;
      cur_note_q   <= 4'd0;
      pend_note_q  <= 4'd0;
      pend_valid_q <= 1'b0;
      square_q     <= 1'b0;
      amp_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      cur_note_q   <= cur_note_d;
      pend_note_q  <= pend_note_d;
      pend_valid_q <= pend_valid_d;
      square_q     <= square_d;
      amp_q        <= amp_d;
    end
  end

  assign bus.square = square_q;
  assign bus.amp    = amp_q;
  assign bus.wave   = square_q ? amp_q : 8'd0;
  assign bus.active = (state_q != IDLE);

endmodule

// File: tb/tb_note_voice.sv
// Bench for note_voice: directed vector table, multi-cycle corner sequences, then random traffic
// compared against a phase-length/envelope model of the voice.
module tb_note_voice;

  localparam int A_STEP = 8;
  localparam int R_STEP = 4;
  localparam int HP_TAB [13] = '{0, 19, 18, 17, 16, 15, 14, 14, 13, 12, 11, 11, 10};

  localparam int M_OFF  = 0;
  localparam int M_RISE = 1;
  localparam int M_HOLD = 2;
  localparam int M_FALL = 3;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  note_voice_if bus();

  note_voice #(
    .ATTACK_STEP  (A_STEP),
    .RELEASE_STEP (R_STEP)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: envelope mode, amplitude, tone level, clocks left in the current half period,
  // sounding note and requested note (0 = nothing requested).
  int m_mode, m_amp, m_hi, m_left, m_cur, m_pend;

  typedef struct {
    int    note;
    bit    on;
    int    cycles;
    bit    sq;
    int    amp;
    bit    act;
    string name;
  } vec_t;

  vec_t tbl [12];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int note, input bit on);
    bus.note_sustain = 4'(note);
    bus.sequencer_on = on;
  endtask

  task automatic check_all(input string name, input int sq, input int amp, input int act);
    checkOutput({name, ".square"}, int'(bus.square), sq);
    checkOutput({name, ".amp"},    int'(bus.amp),    amp);
    checkOutput({name, ".wave"},   int'(bus.wave),   (sq != 0) ? amp : 0);
    checkOutput({name, ".active"}, int'(bus.active), act);
  endtask

  task automatic model_reset();
    m_mode = M_OFF;
    m_amp  = 0;
    m_hi   = 0;
    m_left = 0;
    m_cur  = 0;
    m_pend = 0;
  endtask

  task automatic model_step();
    int n;
    bit v;
    n = int'(bus.note_sustain);
    v = bus.sequencer_on && (n >= 1) && (n <= 12);
    if (m_mode == M_OFF) begin
      if (v) begin
        m_mode = M_RISE;
        m_cur  = n;
        m_hi   = 1;
        m_left = HP_TAB[n];
        m_amp  = 0;
        m_pend = 0;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_hi = (m_hi == 0) ? 1 : 0;
        if (m_pend != 0) begin
          m_cur  = m_pend;
          m_pend = 0;
        end
        m_left = HP_TAB[m_cur];
      end
      if (v && (n != m_cur)) m_pend = n;
      case (m_mode)
        M_RISE: begin
          if (!v) m_mode = M_FALL;
          else begin
            m_amp = (m_amp + A_STEP > 255) ? 255 : m_amp + A_STEP;
            if (m_amp == 255) m_mode = M_HOLD;
          end
        end
        M_HOLD: if (!v) m_mode = M_FALL;
        M_FALL: begin
          if (v) m_mode = M_RISE;
          else begin
            m_amp = (m_amp - R_STEP < 0) ? 0 : m_amp - R_STEP;
            if (m_amp == 0) begin
              m_mode = M_OFF;
              m_hi   = 0;
              m_pend = 0;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    applyStimulus(0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  // Counts edges until square changes level; gives up after 100 so a stuck tone shows as a wrong length.
  task automatic measure_phase(output int len);
    logic start;
    start = bus.square;
    len   = 0;
    do begin
      tick();
      len++;
    end while ((bus.square == start) && (len < 100));
  endtask

  task automatic wait_idle(output int len);
    len = 0;
    do begin
      tick();
      len++;
    end while ((bus.active == 1'b1) && (len < 200));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int len;
    int first_amp;

    tbl[0]  = '{14, 1'b1,  5, 1'b0,   0, 1'b0, "note14_idle"};
    tbl[1]  = '{ 3, 1'b0,  5, 1'b0,   0, 1'b0, "seqoff_idle"};
    tbl[2]  = '{ 0, 1'b1,  3, 1'b0,   0, 1'b0, "note0_idle"};
    tbl[3]  = '{15, 1'b1,  2, 1'b0,   0, 1'b0, "note15_idle"};
    tbl[4]  = '{10, 1'b1,  1, 1'b1,   0, 1'b1, "attack_entry"};
    tbl[5]  = '{10, 1'b1, 10, 1'b1,  80, 1'b1, "k10"};
    tbl[6]  = '{10, 1'b1,  1, 1'b0,  88, 1'b1, "k11_toggle"};
    tbl[7]  = '{10, 1'b1, 10, 1'b0, 168, 1'b1, "k21"};
    tbl[8]  = '{10, 1'b1,  1, 1'b1, 176, 1'b1, "k22_toggle"};
    tbl[9]  = '{10, 1'b1,  9, 1'b1, 248, 1'b1, "k31"};
    tbl[10] = '{10, 1'b1,  1, 1'b1, 255, 1'b1, "k32_sustain"};
    tbl[11] = '{10, 1'b1,  1, 1'b0, 255, 1'b1, "k33_toggle"};

    applyStimulus(0, 1'b0);
    #2;
    check_all("in_reset", 0, 0, 0);
    do_reset();
    check_all("after_reset", 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].note, tbl[i].on);
      repeat (tbl[i].cycles) tick();
      check_all(tbl[i].name, int'(tbl[i].sq), tbl[i].amp, int'(tbl[i].act));
    end

    // Pitch change mid high phase: remaining high time keeps the old pitch.
    measure_phase(len);
    checkOutput("low_n10", len, 11);
    repeat (4) tick();
    applyStimulus(1, 1'b1);
    measure_phase(len);
    checkOutput("high_rest_n10", len, 7);
    measure_phase(len);
    checkOutput("low_n1", len, 19);
    measure_phase(len);
    checkOutput("high_n1", len, 19);
    checkOutput("sustain_amp", int'(bus.amp), 255);

    // Release from full scale.
    applyStimulus(0, 1'b1);
    tick();
    checkOutput("release_entry_amp", int'(bus.amp), 255);
    checkOutput("release_entry_active", int'(bus.active), 1);
    tick();
    first_amp = int'(bus.amp);
    checkOutput("release_first_step", first_amp, 251);
    wait_idle(len);
    checkOutput("release_len", len + 1, 64);
    check_all("release_done", 0, 0, 0);

    // Retrigger during release at amp 128.
    applyStimulus(10, 1'b1);
    repeat (17) tick();
    checkOutput("attack16_amp", int'(bus.amp), 128);
    applyStimulus(0, 1'b1);
    tick();
    checkOutput("rel_hold_amp", int'(bus.amp), 128);
    applyStimulus(5, 1'b1);
    tick();
    checkOutput("retrig_hold_amp", int'(bus.amp), 128);
    len = 0;
    do begin
      tick();
      len++;
    end while ((bus.amp != 8'hFF) && (len < 100));
    checkOutput("retrig_rise_len", len, 16);
    measure_phase(len);
    measure_phase(len);
    checkOutput("n5_phase_a", len, 15);
    measure_phase(len);
    checkOutput("n5_phase_b", len, 15);

    // Asynchronous reset mid attack.
    applyStimulus(0, 1'b1);
    wait_idle(len);
    checkOutput("idle_before_3", int'(bus.active), 0);
    applyStimulus(3, 1'b1);
    repeat (9) tick();
    checkOutput("attack_amp64", int'(bus.amp), 64);
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    check_all("async_reset", 0, 0, 0);
    @(posedge clk);
    #1;
    check_all("reset_held", 0, 0, 0);
    n_rst = 1'b1;
    tick();
    check_all("reentry", 1, 0, 1);
    tick();
    check_all("reentry_step", 1, 8, 1);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(39) == 0) begin
        int pick;
        pick = int'($urandom_range(9));
        if (pick < 6)      applyStimulus(int'($urandom_range(12, 1)), 1'b1);
        else if (pick < 8) applyStimulus(0, 1'b1);
        else if (pick < 9) applyStimulus(int'($urandom_range(15, 13)), 1'b1);
        else               applyStimulus(int'($urandom_range(12, 1)), 1'b0);
      end
      tick();
      check_all("rnd", m_hi, m_amp, (m_mode != M_OFF) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
